legv8_icache_mem: RTL
=====================

// Module: legv8_icache_mem
// PURPOSE
//  4-way set-associative instruction cache storage: tag/valid/data arrays plus line-refill FSM.
//  Responder side of the cache controller interface: takes Index/Tag/Write0..3 and returns hit_status/instr.
//  On a write-enable it fetches the missing word from instruction memory through a req/ack handshake.
//  Line = one 32-bit instruction; address = {Tag, Index, 2'b00}.
// PARAMETERS
//  NUM_SETS  32  sets per way; Index width = log2(NUM_SETS) = 5
//  TAG_W     57  tag width = 64 - 5 - 2
//  DATA_W    32  instruction word width
// PORTS
//  clk          in   1       system clock, all state on posedge
//  rst          in   1       synchronous, active-high reset
//  Index        in   5       set select from controller
//  Tag          in   57      lookup/fill tag from controller
//  Write0..3    in   1 each  way fill request from controller (one-hot expected)
//  hit_status   out  1       1 = Tag matches a valid way in set Index
//  instr        out  32      data of hitting way; 0 on miss
//  busy         out  1       refill in progress
//  refill_done  out  1       one-cycle pulse when fill word written
//  mem_req      out  1       fetch request to instruction memory
//  mem_addr     out  64      fetch byte address
//  mem_ack      in   1       memory response strobe, one cycle
//  mem_data     in   32      fetched word, valid while mem_ack=1
// BEHAVIOUR
//  Arrays: valid[4][32], tag[4][32] (57b), data[4][32] (32b). Only valid resets.
//  Lookup: combinational from Index/Tag vs stored arrays; hit_status=0 whenever busy=1.
//   Multiple matching ways (illegal): lowest way number drives instr.
//  FSM: IDLE -> REQ -> WAIT -> WRITE -> IDLE.
//   IDLE: if any WriteN=1 on posedge, latch way (lowest set bit wins), Index, Tag; go REQ.
//   REQ: mem_req=1, mem_addr={tag_l,idx_l,2'b00}; go WAIT next cycle.
//   WAIT: mem_req held 1 until mem_ack=1; latch mem_data; go WRITE. No timeout.
//   WRITE: data/tag of latched way/set written, valid set; refill_done=1; busy=0 next cycle.
//   mem_ack in REQ also accepted (go WRITE directly). mem_ack in IDLE/WRITE ignored.
//  Latency: WriteN sample to refill_done = 3 cycles with mem_ack on first WAIT cycle.
//  busy=1 in REQ, WAIT, WRITE. WriteN inputs ignored while busy; Index/Tag changes ignored.
//  Fill overwrites target way regardless of its valid/tag (victim chosen by controller).
//  Fill to a way whose tag already exists in another way of the set: allowed, no check.
//  Reset (any state, incl. mid-refill): all valid=0, FSM=IDLE, hit_status=0, instr=0,
//   busy=0, refill_done=0, mem_req=0, mem_addr=0; pending fill discarded, late mem_ack ignored.
// CONFIGURATION
//  ICACHE_STATS_EN defined: adds outputs hit_cnt[31:0], miss_cnt[31:0], reset to 0.
//   hit_cnt +1 each cycle in IDLE with hit_status=1; miss_cnt +1 per IDLE->REQ transition.
//   Both saturate at 32'hFFFF_FFFF (no wrap).
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Reset then Index=3,Tag=0x10 -> hit_status=0, instr=0, busy=0, mem_req=0.
//  Write2=1 Index=3 Tag=0x10; mem_ack 2 cycles later with mem_data=0xD503201F ->
//   mem_addr=0x80C, refill_done pulse; then hit_status=1, instr=0xD503201F.
//  Fill all 4 ways of set 7 with distinct tags/data -> each tag hits its own data; tag 0x99 misses.
//  Write0 during WAIT with different Index -> ignored; only original fill lands, no second mem_req.
//  rst asserted in WAIT, mem_ack next cycle -> no valid bit set, busy=0, set still misses.
//  ICACHE_STATS_EN: 1 miss+fill then 5 hit cycles -> miss_cnt=1, hit_cnt=5; preload 32'hFFFF_FFFF -> stays.

Source files
------------

// File: rtl/legv8_icache_mem.sv
// +----------------------------------------------------------------------------+
// | legv8_icache_mem: 4-way set-associative I-cache arrays with refill FSM.    |
// | Optional ICACHE_STATS_EN macro adds saturating hit/miss counters.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module legv8_icache_mem #(
  parameter int NUM_SETS = 32,
  parameter int TAG_W    = 57,
  parameter int DATA_W   = 32,
  localparam int IDX_W   = $clog2(NUM_SETS),
  localparam int NUM_WAYS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  Index,
  input  logic [TAG_W-1:0]  Tag,
  input  logic              Write0,
  input  logic              Write1,
  input  logic              Write2,
  input  logic              Write3,
  output logic              hit_status,
  output logic [DATA_W-1:0] instr,
  output logic              busy,
  output logic              refill_done,
  output logic              mem_req,
  output logic [63:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_SETS-1:0] r_valid    [NUM_WAYS];
  logic [TAG_W-1:0]    r_tag_mem  [NUM_WAYS][NUM_SETS];
  logic [DATA_W-1:0]   r_data_mem [NUM_WAYS][NUM_SETS];

  logic [1:0]          r_way;
  logic [IDX_W-1:0]    r_idx;
  logic [TAG_W-1:0]    r_tag;
  logic [DATA_W-1:0]   r_fill_data;

  logic                w_wr_any;
  logic [1:0]          w_wr_way;
  logic                w_hit;
  logic [DATA_W-1:0]   w_hit_data;
  logic                w_start;
  logic                w_ack_take;

  // Lowest-numbered asserted Write line selects the fill way.
  always_comb begin
    w_wr_any = Write0 | Write1 | Write2 | Write3;
    if (Write0)      w_wr_way = 2'd0;
    else if (Write1) w_wr_way = 2'd1;
    else if (Write2) w_wr_way = 2'd2;
    else             w_wr_way = 2'd3;
  end

  // Scanning from the top way down lets the lowest matching way win.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (r_valid[w][Index] && (r_tag_mem[w][Index] == Tag)) begin
        w_hit      = 1'b1;
        w_hit_data = r_data_mem[w][Index];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_ack_take  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_wr_any) begin
          w_start     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_ack_take  = mem_ack;
        w_state_nxt = mem_ack ? S_WRITE : S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack) begin
          w_ack_take  = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_way       <= '0;
      r_idx       <= '0;
      r_tag       <= '0;
      r_fill_data <= '0;
    end else begin
      if (w_start) begin
        r_way <= w_wr_way;
        r_idx <= Index;
        r_tag <= Tag;
      end
      if (w_ack_take) r_fill_data <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WAYS; w++) r_valid[w] <= '0;
    end else if (r_state == S_WRITE) begin
      r_valid[r_way][r_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (r_state == S_WRITE) begin
      r_tag_mem[r_way][r_idx]  <= r_tag;
      r_data_mem[r_way][r_idx] <= r_fill_data;
    end
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    refill_done = (r_state == S_WRITE);
    mem_req     = (r_state == S_REQ) || (r_state == S_WAIT);
    mem_addr    = mem_req ? {r_tag, r_idx, 2'b00} : 64'd0;
    hit_status  = w_hit & ~busy;
    instr       = hit_status ? w_hit_data : '0;
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if ((r_state == S_IDLE) && hit_status && (hit_cnt != 32'hFFFF_FFFF))
        hit_cnt <= hit_cnt + 32'd1;
      if (w_start && (miss_cnt != 32'hFFFF_FFFF))
        miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire
